// File: rtl/sdram_port_arbiter.sv
// Two-port Avalon-MM arbiter in front of one SDRAM controller.
// Round-robin grant between m0 and m1, commands routed combinationally in
// the granted state. An order FIFO of port ids steers in-order read
// responses back to the requester that issued each read.
//
// Handshake: a transfer is accepted in the cycle where the command strobe
// (read or write) is high and waitrequest is low; the requester holds
// address/data/strobes stable while its waitrequest is high. Read data is
// valid only in a cycle where readdatavalid is high.
module sdram_port_arbiter #(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = 4
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    // requester 0
    input  logic [ADDR_W-1:0]           m0_address,
    input  logic                        m0_read,
    input  logic                        m0_write,
    input  logic [DATA_W-1:0]           m0_writedata,
    input  logic [DATA_W/8-1:0]         m0_byteenable,
    output logic                        m0_waitrequest,
    output logic [DATA_W-1:0]           m0_readdata,
    output logic                        m0_readdatavalid,
    // requester 1
    input  logic [ADDR_W-1:0]           m1_address,
    input  logic                        m1_read,
    input  logic                        m1_write,
    input  logic [DATA_W-1:0]           m1_writedata,
    input  logic [DATA_W/8-1:0]         m1_byteenable,
    output logic                        m1_waitrequest,
    output logic [DATA_W-1:0]           m1_readdata,
    output logic                        m1_readdatavalid,
    // SDRAM controller side
    output logic [ADDR_W-1:0]           s_address,
    output logic [DATA_W-1:0]           s_writedata,
    output logic [DATA_W/8-1:0]         s_byteenable,
    output logic                        s_read,
    output logic                        s_write,
    input  logic                        s_waitrequest,
    input  logic [DATA_W-1:0]           s_readdata,
    input  logic                        s_readdatavalid,
    // status / debug
    output logic                        rd_err,
    output logic [1:0]                  dbg_state_o,
    output logic [$clog2(MAX_PEND):0]   dbg_pend_cnt_o
);

    localparam int PTR_W = $clog2(MAX_PEND);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t               state_q;
    logic                 rr_ptr_q;
    logic [MAX_PEND-1:0]  tag_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     pend_cnt_q;
    logic [CNT_W-1:0]     pend_cnt_d;
    logic                 rd_err_q;

    logic full;
    logic empty;
    logic elig0;
    logic elig1;
    logic accept;
    logic push;
    logic pop;
    logic head_port;

    assign full   = (pend_cnt_q == CNT_W'(MAX_PEND));
    assign empty  = (pend_cnt_q == '0);
    // A write is always eligible; a read only while the order FIFO has room.
    assign elig0  = m0_write | (m0_read & ~full);
    assign elig1  = m1_write | (m1_read & ~full);

    assign accept    = (s_read | s_write) & ~s_waitrequest;
    assign push      = accept & s_read;
    assign pop       = s_readdatavalid & ~empty;
    assign head_port = tag_q[rd_ptr_q];

    // Command mux: the granted port drives the controller, everyone else stalls.
    // A read held while the FIFO is full is masked and stalled until room frees.
    always_comb begin
        s_address      = '0;
        s_writedata    = '0;
        s_byteenable   = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state_q)
            ST_GNT0: begin
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                s_read         = m0_read & ~full;
                s_write        = m0_write;
                m0_waitrequest = s_waitrequest | (m0_read & full);
            end
            ST_GNT1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_read         = m1_read & ~full;
                s_write        = m1_write;
                m1_waitrequest = s_waitrequest | (m1_read & full);
            end
            default: ;
        endcase
    end

    // Response steering: the FIFO head names the port owning this beat.
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop & ~head_port;
    assign m1_readdatavalid = pop &  head_port;

    // Arbiter FSM: round-robin pointer flips on every accepted transfer.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (elig0 && elig1) begin
                        state_q <= rr_ptr_q ? ST_GNT1 : ST_GNT0;
                    end else if (elig0) begin
                        state_q <= ST_GNT0;
                    end else if (elig1) begin
                        state_q <= ST_GNT1;
                    end
                end
                ST_GNT0: begin
                    if (accept) begin
                        rr_ptr_q <= 1'b1;
                        if (elig1) begin
                            state_q <= ST_GNT1;
                        end else if (!elig0) begin
                            state_q <= ST_IDLE;
                        end
                    end else if (!(m0_read || m0_write)) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_GNT1: begin
                    if (accept) begin
                        rr_ptr_q <= 1'b0;
                        if (elig0) begin
                            state_q <= ST_GNT0;
                        end else if (!elig1) begin
                            state_q <= ST_IDLE;
                        end
                    end else if (!(m1_read || m1_write)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outstanding-read count: simultaneous push and pop cancel out.
    always_comb begin
        pend_cnt_d = pend_cnt_q;
        case ({push, pop})
            2'b10:   pend_cnt_d = pend_cnt_q + CNT_W'(1);
            2'b01:   pend_cnt_d = pend_cnt_q - CNT_W'(1);
            default: pend_cnt_d = pend_cnt_q;
        endcase
    end

    // Order FIFO of port ids; pointers wrap naturally at MAX_PEND.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pend_cnt_q <= '0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= (state_q == ST_GNT1);
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Sticky flag for a response beat that no issued read accounts for.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rd_err_q <= 1'b0;
        end else if (s_readdatavalid && empty) begin
            rd_err_q <= 1'b1;
        end
    end

    assign rd_err         = rd_err_q;
    assign dbg_state_o    = state_q;
    assign dbg_pend_cnt_o = pend_cnt_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios followed by a random
// two-master traffic phase scored against an ideal shared-memory model.
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_reset;

    logic [24:0] m_address     [2];
    logic        m_read        [2];
    logic        m_write       [2];
    logic [15:0] m_writedata   [2];
    logic [1:0]  m_byteenable  [2];
    logic        m_waitrequest [2];
    logic [15:0] m_readdata    [2];
    logic        m_rdv         [2];

    logic [24:0] s_address;
    logic [15:0] s_writedata;
    logic [1:0]  s_byteenable;
    logic        s_read;
    logic        s_write;
    logic        s_waitrequest;
    logic [15:0] s_readdata;
    logic        s_readdatavalid;
    logic        rd_err;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_pend_cnt;

    int checks   = 0;
    int failures = 0;

    // scoreboard state
    logic [15:0] ref_mem [16];
    logic [15:0] slv_mem [16];
    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];
    logic [15:0] resp_q [$];
    bit          busy     [2];
    int          wait_cnt [2];
    int          max_wait;

    sdram_port_arbiter dut (
        .clk_clk          (clk),
        .reset_reset      (reset_reset),
        .m0_address       (m_address[0]),
        .m0_read          (m_read[0]),
        .m0_write         (m_write[0]),
        .m0_writedata     (m_writedata[0]),
        .m0_byteenable    (m_byteenable[0]),
        .m0_waitrequest   (m_waitrequest[0]),
        .m0_readdata      (m_readdata[0]),
        .m0_readdatavalid (m_rdv[0]),
        .m1_address       (m_address[1]),
        .m1_read          (m_read[1]),
        .m1_write         (m_write[1]),
        .m1_writedata     (m_writedata[1]),
        .m1_byteenable    (m_byteenable[1]),
        .m1_waitrequest   (m_waitrequest[1]),
        .m1_readdata      (m_readdata[1]),
        .m1_readdatavalid (m_rdv[1]),
        .s_address        (s_address),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .rd_err           (rd_err),
        .dbg_state_o      (dbg_state),
        .dbg_pend_cnt_o   (dbg_pend_cnt)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] be);
        merge = old;
        if (be[0]) merge[7:0]  = d[7:0];
        if (be[1]) merge[15:8] = d[15:8];
    endfunction

    task automatic idle_inputs();
        for (int p = 0; p < 2; p++) begin
            m_address[p]    = '0;
            m_read[p]       = 1'b0;
            m_write[p]      = 1'b0;
            m_writedata[p]  = '0;
            m_byteenable[p] = 2'b11;
        end
        s_waitrequest   = 1'b0;
        s_readdata      = '0;
        s_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset_reset = 1'b0;
    endtask

    // Single transfer on port p, held until accepted (bounded).
    task automatic do_xfer(input int p, input bit rd, input logic [24:0] a, input logic [15:0] d);
        int  n;
        bit  done;
        @(negedge clk);
        m_address[p]    = a;
        m_writedata[p]  = d;
        m_byteenable[p] = 2'b11;
        m_read[p]       = rd;
        m_write[p]      = !rd;
        n    = 0;
        done = 1'b0;
        while (!done && n < 32) begin
            #1;
            if (m_waitrequest[p] == 1'b0) begin
                done = 1'b1;
                chk("xfer_addr", s_address, a);
                chk("xfer_cmd", {s_read, s_write}, {rd, !rd});
            end else begin
                n++;
                @(negedge clk);
            end
        end
        chk("xfer_accepted", done, 1);
        @(negedge clk);
        m_read[p]  = 1'b0;
        m_write[p] = 1'b0;
    endtask

    // One cycle of random two-master traffic with a random-latency slave.
    task automatic rand_cycle(input bit allow_new);
        int n_acc;
        int acc_p;
        bit s_acc;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (!busy[p]) begin
                m_read[p]  = 1'b0;
                m_write[p] = 1'b0;
                if (allow_new && $urandom_range(0, 9) < 4) begin
                    busy[p]     = 1'b1;
                    wait_cnt[p] = 0;
                    if ($urandom_range(0, 1) == 1) m_read[p] = 1'b1;
                    else                           m_write[p] = 1'b1;
                    m_address[p]    = 25'($urandom_range(0, 15));
                    m_writedata[p]  = 16'($urandom);
                    m_byteenable[p] = 2'($urandom_range(1, 3));
                end
            end
        end
        s_waitrequest = ($urandom_range(0, 3) == 0);
        if (resp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            s_readdatavalid = 1'b1;
            s_readdata      = resp_q.pop_front();
        end else begin
            s_readdatavalid = 1'b0;
            s_readdata      = 16'($urandom);
        end
        #1;
        // slave (SDRAM) view
        s_acc = (s_read || s_write) && !s_waitrequest;
        if (s_read && !s_waitrequest) resp_q.push_back(slv_mem[s_address[3:0]]);
        if (s_write && !s_waitrequest)
            slv_mem[s_address[3:0]] = merge(slv_mem[s_address[3:0]], s_writedata, s_byteenable);
        // response routing
        chk("rdv_onehot", 32'(m_rdv[0]) + 32'(m_rdv[1]), 32'(s_readdatavalid));
        if (m_rdv[0]) begin
            chk("rd0_expected", exp_q0.size() > 0, 1);
            if (exp_q0.size() > 0) chk("rd0_data", m_readdata[0], exp_q0.pop_front());
        end
        if (m_rdv[1]) begin
            chk("rd1_expected", exp_q1.size() > 0, 1);
            if (exp_q1.size() > 0) chk("rd1_data", m_readdata[1], exp_q1.pop_front());
        end
        // master view against the ideal memory
        n_acc = 0;
        acc_p = 0;
        for (int p = 0; p < 2; p++) begin
            if (busy[p] && !m_waitrequest[p]) begin
                n_acc++;
                acc_p   = p;
                busy[p] = 1'b0;
                if (m_read[p]) begin
                    if (p == 0) exp_q0.push_back(ref_mem[m_address[p][3:0]]);
                    else        exp_q1.push_back(ref_mem[m_address[p][3:0]]);
                end else begin
                    ref_mem[m_address[p][3:0]] =
                        merge(ref_mem[m_address[p][3:0]], m_writedata[p], m_byteenable[p]);
                end
            end else if (busy[p]) begin
                wait_cnt[p]++;
                if (wait_cnt[p] > max_wait) max_wait = wait_cnt[p];
            end
        end
        chk("one_accept", n_acc <= 1, 1);
        chk("slave_sees_accept", s_acc, n_acc == 1);
        if (n_acc == 1) begin
            chk("slave_addr", s_address, m_address[acc_p]);
            chk("slave_cmd", {s_read, s_write}, {m_read[acc_p], m_write[acc_p]});
        end
    endtask

    initial begin
        logic [15:0] vals [3];
        int          ports [3];
        int          owner;
        int          n;

        // reset state
        reset_reset = 1'b1;
        idle_inputs();
        #1;
        chk("rst_s_read", s_read, 0);
        chk("rst_s_write", s_write, 0);
        chk("rst_wait", {m_waitrequest[0], m_waitrequest[1]}, 2'b11);
        chk("rst_rdv", {m_rdv[0], m_rdv[1]}, 2'b00);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_pend", dbg_pend_cnt, 0);
        @(negedge clk);
        reset_reset = 1'b0;

        // single write: visible on the slave one cycle after request
        @(negedge clk);
        m_address[0]   = 25'h000123;
        m_writedata[0] = 16'hBEEF;
        m_write[0]     = 1'b1;
        #1;
        chk("w_first_cycle_wait", m_waitrequest[0], 1);
        chk("w_first_cycle_cmd", s_write, 0);
        @(negedge clk);
        #1;
        chk("w_s_write", s_write, 1);
        chk("w_s_address", s_address, 25'h000123);
        chk("w_s_data", s_writedata, 16'hBEEF);
        chk("w_m0_wait", m_waitrequest[0], 0);
        chk("w_m1_wait", m_waitrequest[1], 1);
        @(negedge clk);
        m_write[0] = 1'b0;
        @(negedge clk);
        #1;
        chk("w_back_idle_wait", {m_waitrequest[0], m_waitrequest[1]}, 2'b11);
        chk("w_back_idle_cmd", {s_read, s_write}, 2'b00);

        // contention from reset: grants alternate starting at m0
        do_reset();
        @(negedge clk);
        m_address[0] = 25'h10; m_write[0] = 1'b1; m_writedata[0] = 16'h0A0A;
        m_address[1] = 25'h20; m_write[1] = 1'b1; m_writedata[1] = 16'h0B0B;
        #1;
        chk("cont_idle", {m_waitrequest[0], m_waitrequest[1]}, 2'b11);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            owner = !m_waitrequest[0] ? 0 : (!m_waitrequest[1] ? 1 : 2);
            chk("cont_owner", owner, k % 2);
            chk("cont_addr", s_address, (k % 2) ? 25'h20 : 25'h10);
        end
        @(negedge clk);
        m_write[0] = 1'b0;
        m_write[1] = 1'b0;

        // read routing keeps issue order across ports
        do_reset();
        do_xfer(0, 1'b1, 25'h100, 16'h0);
        do_xfer(1, 1'b1, 25'h200, 16'h0);
        do_xfer(0, 1'b1, 25'h300, 16'h0);
        @(negedge clk);
        #1;
        chk("route_pend", dbg_pend_cnt, 3);
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        ports[0] = 0;       ports[1] = 1;       ports[2] = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_readdatavalid = 1'b1;
            s_readdata      = vals[i];
            #1;
            chk("route_rdv0", m_rdv[0], ports[i] == 0);
            chk("route_rdv1", m_rdv[1], ports[i] == 1);
            chk("route_data0", m_readdata[0], vals[i]);
            chk("route_data1", m_readdata[1], vals[i]);
        end
        @(negedge clk);
        s_readdatavalid = 1'b0;
        #1;
        chk("route_pend_done", dbg_pend_cnt, 0);

        // full FIFO: 4 back-to-back reads, 5th stalls until the first response
        do_reset();
        @(negedge clk);
        m_read[0]    = 1'b1;
        m_address[0] = 25'h40;
        #1;
        chk("full_idle_wait", m_waitrequest[0], 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m_address[0] = 25'(25'h40 + i);
            #1;
            chk("full_b2b_read", s_read, 1);
            chk("full_b2b_addr", s_address, 25'h40 + i);
            chk("full_b2b_wait", m_waitrequest[0], 0);
        end
        @(negedge clk);
        m_address[0]   = 25'h44;
        m_write[1]     = 1'b1;
        m_address[1]   = 25'h99;
        m_writedata[1] = 16'h5A5A;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("full_hold_read", s_read, 0);
            chk("full_hold_wait0", m_waitrequest[0], 1);
            chk("full_hold_wait1", m_waitrequest[1], 1);
            chk("full_hold_pend", dbg_pend_cnt, 4);
            @(negedge clk);
        end
        s_readdatavalid = 1'b1;
        s_readdata      = 16'h00A0;
        #1;
        chk("full_first_rdv", m_rdv[0], 1);
        chk("full_first_rdv1", m_rdv[1], 0);
        chk("full_still_held", s_read, 0);
        @(negedge clk);
        s_readdatavalid = 1'b0;
        #1;
        chk("full_5th_issue", s_read, 1);
        chk("full_5th_addr", s_address, 25'h44);
        chk("full_5th_wait", m_waitrequest[0], 0);
        @(negedge clk);
        m_read[0] = 1'b0;
        #1;
        chk("full_write_cmd", s_write, 1);
        chk("full_write_addr", s_address, 25'h99);
        chk("full_write_data", s_writedata, 16'h5A5A);
        chk("full_write_wait", m_waitrequest[1], 0);
        @(negedge clk);
        m_write[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_readdatavalid = 1'b1;
            s_readdata      = 16'(16'h00B0 + i);
            #1;
            chk("full_drain_rdv0", m_rdv[0], 1);
            chk("full_drain_rdv1", m_rdv[1], 0);
            @(negedge clk);
        end
        s_readdatavalid = 1'b0;
        #1;
        chk("full_drain_pend", dbg_pend_cnt, 0);

        // stray response with nothing pending
        @(negedge clk);
        s_readdatavalid = 1'b1;
        #1;
        chk("stray_rdv", {m_rdv[0], m_rdv[1]}, 2'b00);
        @(negedge clk);
        s_readdatavalid = 1'b0;
        #1;
        chk("stray_rd_err", rd_err, 1);
        chk("stray_pend", dbg_pend_cnt, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("stray_sticky", rd_err, 1);
        do_reset();
        #1;
        chk("stray_cleared", rd_err, 0);

        // reset in the middle of a grant with 3 reads pending
        do_xfer(0, 1'b1, 25'h10, 16'h0);
        do_xfer(1, 1'b1, 25'h11, 16'h0);
        do_xfer(0, 1'b1, 25'h12, 16'h0);
        @(negedge clk);
        m_write[1]    = 1'b1;
        m_address[1]  = 25'h55;
        s_waitrequest = 1'b1;
        n = 0;
        #1;
        while (!s_write && n < 8) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("mid_pre_grant", s_write, 1);
        chk("mid_pre_pend", dbg_pend_cnt, 3);
        #1;
        reset_reset     = 1'b1;
        s_readdatavalid = 1'b1;
        #1;
        chk("mid_rst_cmd", {s_read, s_write}, 2'b00);
        chk("mid_rst_wait", {m_waitrequest[0], m_waitrequest[1]}, 2'b11);
        chk("mid_rst_rdv", {m_rdv[0], m_rdv[1]}, 2'b00);
        chk("mid_rst_pend", dbg_pend_cnt, 0);
        chk("mid_rst_err", rd_err, 0);
        @(negedge clk);
        idle_inputs();
        reset_reset = 1'b0;
        @(negedge clk);
        s_readdatavalid = 1'b1;
        #1;
        chk("mid_late_rdv", {m_rdv[0], m_rdv[1]}, 2'b00);
        @(negedge clk);
        s_readdatavalid = 1'b0;
        #1;
        chk("mid_late_err", rd_err, 1);
        chk("mid_late_pend", dbg_pend_cnt, 0);

        // random two-master traffic against the ideal memory model
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 16'(16'h1000 + i * 16'h0111);
            slv_mem[i] = 16'(16'h1000 + i * 16'h0111);
        end
        busy[0] = 1'b0; busy[1] = 1'b0;
        wait_cnt[0] = 0; wait_cnt[1] = 0;
        max_wait = 0;
        for (int i = 0; i < 600; i++) rand_cycle(1'b1);
        n = 0;
        while ((busy[0] || busy[1] || exp_q0.size() > 0 || exp_q1.size() > 0 ||
                resp_q.size() > 0) && n < 400) begin
            rand_cycle(1'b0);
            n++;
        end
        chk("rand_drained", busy[0] || busy[1] || exp_q0.size() > 0 || exp_q1.size() > 0, 0);
        chk("rand_no_starve", max_wait < 100, 1);
        chk("rand_no_err", rd_err, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rand_pend_zero", dbg_pend_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
